// File: rtl/pie_cmd_encoder_if.sv
// Command and bit-stream bundle for the PIE command encoder.
// master: command/bit source; slave: encoder (drives bit_ready).
interface pie_cmd_encoder_if #(
    parameter int LEN_W = 8
);
    logic             cmd_start;
    logic             cmd_preamble;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_abort;
    logic             bit_data;
    logic             bit_valid;
    logic             bit_ready;

    modport master (
        output cmd_start,
        output cmd_preamble,
        output cmd_len,
        output cmd_abort,
        output bit_data,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  cmd_start,
        input  cmd_preamble,
        input  cmd_len,
        input  cmd_abort,
        input  bit_data,
        input  bit_valid,
        output bit_ready
    );
endinterface

// File: rtl/pie_cmd_encoder.sv
// Reader-to-tag PIE command encoder: delimiter, data-0, RTCAL,
// optional TRCAL, then PIE-coded bits fetched over cmd_if.
// Ports: clk_10m, rst_n (async low), cmd_if (slave),
// rd_data (1=carrier), busy, done/err_underrun (1-cycle pulses).
module pie_cmd_encoder #(
    parameter int TARI_CYC  = 125,
    parameter int DATA1_CYC = 250,
    parameter int PW_CYC    = 63,
    parameter int DELIM_CYC = 125,
    parameter int TRCAL_CYC = 500,
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 12
) (
    input  logic             clk_10m,
    input  logic             rst_n,
    pie_cmd_encoder_if.slave cmd_if,
    output logic             rd_data,
    output logic             busy,
    output logic             done,
    output logic             err_underrun
);

    typedef enum logic [2:0] {
        IDLE,
        DELIM,
        D0,
        RTCAL,
        TRCAL,
        DATA
    } state_t;

    localparam logic [CNT_W-1:0] L_TARI  = CNT_W'(TARI_CYC);
    localparam logic [CNT_W-1:0] L_DATA1 = CNT_W'(DATA1_CYC);
    localparam logic [CNT_W-1:0] L_PW    = CNT_W'(PW_CYC);
    localparam logic [CNT_W-1:0] L_DELIM = CNT_W'(DELIM_CYC);
    localparam logic [CNT_W-1:0] L_TRCAL = CNT_W'(TRCAL_CYC);
    localparam logic [CNT_W-1:0] L_RTCAL =
        CNT_W'(TARI_CYC + DATA1_CYC);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] sym_len;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] nxt_len;
    logic [LEN_W-1:0] bits_left;
    logic [LEN_W-1:0] nxt_bits;
    logic             preamble;
    logic             nxt_pre;
    logic             nxt_done;
    logic             nxt_under;
    logic             nxt_fetch;
    logic             nxt_rd;
    logic             bit_ready;
    logic             last;
    logic             fetch_go;
    logic             to_idle;

    assign cmd_if.bit_ready = bit_ready;
    assign last = (sym_cnt == sym_len - CNT_W'(1));

    always_comb begin
        nxt_state = state;
        nxt_cnt   = sym_cnt + CNT_W'(1);
        nxt_len   = sym_len;
        nxt_bits  = bits_left;
        nxt_pre   = preamble;
        nxt_done  = 1'b0;
        nxt_under = 1'b0;
        fetch_go  = 1'b0;
        to_idle   = 1'b0;

        if (state == IDLE) begin
            nxt_cnt = '0;
            // abort wins over a same-cycle start
            if (!cmd_if.cmd_abort && cmd_if.cmd_start &&
                cmd_if.cmd_len != '0) begin
                nxt_state = DELIM;
                nxt_len   = L_DELIM;
                nxt_bits  = cmd_if.cmd_len;
                nxt_pre   = cmd_if.cmd_preamble;
            end
        end else if (cmd_if.cmd_abort) begin
            to_idle = 1'b1;
        end else if (last) begin
            nxt_cnt = '0;
            unique case (state)
                DELIM: begin
                    nxt_state = D0;
                    nxt_len   = L_TARI;
                end
                D0: begin
                    nxt_state = RTCAL;
                    nxt_len   = L_RTCAL;
                end
                RTCAL: begin
                    if (preamble) begin
                        nxt_state = TRCAL;
                        nxt_len   = L_TRCAL;
                    end else begin
                        fetch_go = 1'b1;
                    end
                end
                TRCAL: fetch_go = 1'b1;
                DATA: begin
                    // bits_left counts the symbol now ending
                    if (bits_left == LEN_W'(1)) begin
                        to_idle  = 1'b1;
                        nxt_done = 1'b1;
                    end else begin
                        nxt_bits = bits_left - LEN_W'(1);
                        fetch_go = 1'b1;
                    end
                end
                default: to_idle = 1'b1;
            endcase

            if (fetch_go) begin
                if (cmd_if.bit_valid) begin
                    nxt_state = DATA;
                    nxt_len   = cmd_if.bit_data ? L_DATA1 : L_TARI;
                end else begin
                    to_idle   = 1'b1;
                    nxt_under = 1'b1;
                end
            end
        end

        if (to_idle) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_len   = '0;
            nxt_bits  = '0;
        end
    end

    // Outputs are registered from the next state so that they line
    // up with the symbol position held in state/sym_cnt.
    always_comb begin
        nxt_rd    = 1'b1;
        nxt_fetch = 1'b0;
        unique case (1'b1)
            (nxt_state == IDLE):  nxt_rd = 1'b1;
            (nxt_state == DELIM): nxt_rd = 1'b0;
            default: nxt_rd = (nxt_cnt < nxt_len - L_PW);
        endcase
        if (nxt_cnt == nxt_len - CNT_W'(1)) begin
            unique case (1'b1)
                (nxt_state == RTCAL): nxt_fetch = !nxt_pre;
                (nxt_state == TRCAL): nxt_fetch = 1'b1;
                (nxt_state == DATA):
                    nxt_fetch = (nxt_bits != LEN_W'(1));
                default: nxt_fetch = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_10m or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sym_cnt      <= '0;
            sym_len      <= '0;
            bits_left    <= '0;
            preamble     <= 1'b0;
            rd_data      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
            bit_ready    <= 1'b0;
        end else begin
            state        <= nxt_state;
            sym_cnt      <= nxt_cnt;
            sym_len      <= nxt_len;
            bits_left    <= nxt_bits;
            preamble     <= nxt_pre;
            rd_data      <= nxt_rd;
            busy         <= (nxt_state != IDLE);
            done         <= nxt_done;
            err_underrun <= nxt_under;
            bit_ready    <= nxt_fetch;
        end
    end

endmodule

// File: tb/tb_pie_cmd_encoder.sv
// Self-checking bench for pie_cmd_encoder: vector table, random
// frames against a symbol-list waveform model, corner sequences.
`timescale 1ns/1ps
module tb_pie_cmd_encoder;

    localparam int TARI  = 125;
    localparam int DATA1 = 250;
    localparam int PW    = 63;
    localparam int DELIM = 125;
    localparam int TRCAL = 500;
    localparam int LEN_W = 8;
    localparam int CNT_W = 12;

    logic clk_10m = 1'b0;
    logic rst_n   = 1'b0;
    logic rd_data;
    logic busy;
    logic done;
    logic err_underrun;

    pie_cmd_encoder_if #(.LEN_W(LEN_W)) cmd_if();

    pie_cmd_encoder #(
        .TARI_CYC (TARI),
        .DATA1_CYC(DATA1),
        .PW_CYC   (PW),
        .DELIM_CYC(DELIM),
        .TRCAL_CYC(TRCAL),
        .LEN_W    (LEN_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_10m     (clk_10m),
        .rst_n       (rst_n),
        .cmd_if      (cmd_if),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .err_underrun(err_underrun)
    );

    always #50 clk_10m = ~clk_10m;

    typedef struct {
        bit         pre;
        int         len;
        logic [7:0] bits;
        int         cyc;
        int         rdy;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    bit exp_q[$];
    bit got_rd[$];
    bit got_busy[$];
    bit got_done[$];
    bit got_err[$];
    bit got_rdy[$];

    task automatic check(input string nm, input int got,
                         input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Model: a frame is a list of symbols, each high then PW low.
    function automatic void push_sym(input int l);
        for (int i = 0; i < l; i++) exp_q.push_back(i < l - PW);
    endfunction

    function automatic int build_exp(input bit pre,
                                     input bit bits[$]);
        exp_q.delete();
        for (int i = 0; i < DELIM; i++) exp_q.push_back(1'b0);
        push_sym(TARI);
        push_sym(TARI + DATA1);
        if (pre) push_sym(TRCAL);
        foreach (bits[i]) push_sym(bits[i] ? DATA1 : TARI);
        return exp_q.size();
    endfunction

    function automatic int ones(input bit q[$], input int a,
                                input int b);
        int c = 0;
        for (int i = a; i <= b && i < q.size(); i++)
            c += int'(q[i]);
        return c;
    endfunction

    function automatic int first1(input bit q[$]);
        foreach (q[i]) if (q[i]) return i;
        return -1;
    endfunction

    // Sample k (k>=1) corresponds to model index k-1.
    function automatic int wave_mism(input int a, input int b);
        int m = 0;
        for (int k = a; k <= b; k++) begin
            if (k >= got_rd.size() || k - 1 >= exp_q.size())
                m++;
            else if (got_rd[k] != exp_q[k-1])
                m++;
        end
        return m;
    endfunction

    // Sample 0 is the cycle in which cmd_start is driven.
    task automatic drive_frame(input bit pre, input int len,
                               input bit bits[$], input int n,
                               input int drop_fetch,
                               input int abort_idx,
                               input int mid_idx);
        int k  = 0;
        int nf = 0;
        bit fetch;
        got_rd.delete();
        got_busy.delete();
        got_done.delete();
        got_err.delete();
        got_rdy.delete();
        cmd_if.cmd_start    = 1'b1;
        cmd_if.cmd_preamble = pre;
        cmd_if.cmd_len      = LEN_W'(len);
        cmd_if.cmd_abort    = (abort_idx == 0);
        cmd_if.bit_valid    = (drop_fetch != 1);
        cmd_if.bit_data     = (bits.size() > 0) ? bits[0] : 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_10m);
            got_rd.push_back(rd_data);
            got_busy.push_back(busy);
            got_done.push_back(done);
            got_err.push_back(err_underrun);
            got_rdy.push_back(cmd_if.bit_ready);
            fetch = cmd_if.bit_ready;
            @(posedge clk_10m);
            #1;
            if (fetch) begin
                nf++;
                k++;
                cmd_if.bit_data = (k < bits.size()) ? bits[k] : 1'b0;
            end
            cmd_if.bit_valid = !(drop_fetch != 0 &&
                                 nf + 1 == drop_fetch);
            cmd_if.cmd_abort = (i + 1 == abort_idx);
            cmd_if.cmd_start = (i + 1 == mid_idx);
            if (i + 1 == mid_idx) begin
                cmd_if.cmd_len      = 8'd5;
                cmd_if.cmd_preamble = !pre;
            end
        end
        cmd_if.cmd_start = 1'b0;
        cmd_if.cmd_abort = 1'b0;
    endtask

    task automatic check_frame(input string nm, input int total,
                               input int rdy);
        check({nm, "_wave"}, wave_mism(1, total), 0);
        check({nm, "_done_at"}, first1(got_done), total + 1);
        check({nm, "_done_cnt"}, ones(got_done, 0, total + 2), 1);
        check({nm, "_busy_cnt"}, ones(got_busy, 0, total + 2), total);
        check({nm, "_rd_end"}, ones(got_rd, total + 1, total + 2), 2);
        check({nm, "_rdy_cnt"}, ones(got_rdy, 0, total + 2), rdy);
        check({nm, "_err_cnt"}, ones(got_err, 0, total + 2), 0);
    endtask

    initial begin
        vec_t vecs[5];
        bit   bq[$];
        bit   empty_q[$];
        int   total;
        int   u;
        int   len;
        bit   pre;

        // frame cycles = 625 (+500 TRCAL) + 125 per 0 / 250 per 1
        vecs[0] = '{1'b0, 2, 8'b0000_0001, 1000, 2};
        vecs[1] = '{1'b1, 1, 8'b0000_0000, 1250, 1};
        vecs[2] = '{1'b0, 1, 8'b0000_0001,  875, 1};
        vecs[3] = '{1'b1, 3, 8'b0000_0011, 1750, 3};
        vecs[4] = '{1'b0, 4, 8'b0000_1010, 1375, 4};

        cmd_if.cmd_start    = 1'b0;
        cmd_if.cmd_preamble = 1'b0;
        cmd_if.cmd_len      = '0;
        cmd_if.cmd_abort    = 1'b0;
        cmd_if.bit_data     = 1'b0;
        cmd_if.bit_valid    = 1'b0;

        repeat (3) @(negedge clk_10m);
        check("reset_outs", int'({rd_data, busy, done,
              cmd_if.bit_ready, err_underrun}), 16);
        @(posedge clk_10m);
        #1;
        rst_n = 1'b1;
        @(posedge clk_10m);
        #1;

        foreach (vecs[v]) begin
            bq.delete();
            for (int i = 0; i < vecs[v].len; i++)
                bq.push_back(vecs[v].bits[i]);
            void'(build_exp(vecs[v].pre, bq));
            drive_frame(vecs[v].pre, vecs[v].len, bq,
                        vecs[v].cyc + 3, 0, -1, -1);
            check_frame($sformatf("vec%0d", v), vecs[v].cyc,
                        vecs[v].rdy);
        end

        for (int r = 0; r < 4; r++) begin
            pre = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 6));
            bq.delete();
            for (int i = 0; i < len; i++)
                bq.push_back(1'($urandom_range(0, 1)));
            total = build_exp(pre, bq);
            drive_frame(pre, len, bq, total + 3, 0, -1, -1);
            check_frame($sformatf("rnd%0d", r), total, len);
        end

        // longest command, all zeros
        bq.delete();
        for (int i = 0; i < 255; i++) bq.push_back(1'b0);
        total = build_exp(1'b0, bq);
        drive_frame(1'b0, 255, bq, total + 3, 0, -1, -1);
        check_frame("maxlen", total, 255);

        // underrun at the second fetch (end of first data bit)
        bq.delete();
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        void'(build_exp(1'b0, bq));
        u = 1 + DELIM + TARI + (TARI + DATA1) + DATA1;
        drive_frame(1'b0, 3, bq, u + 20, 2, -1, -1);
        check("und_wave", wave_mism(1, u - 1), 0);
        check("und_err_at", first1(got_err), u);
        check("und_err_cnt", ones(got_err, 0, u + 19), 1);
        check("und_done", ones(got_done, 0, u + 19), 0);
        check("und_rd_hi", ones(got_rd, u, u + 19), 20);
        check("und_busy", ones(got_busy, u, u + 19), 0);

        // abort during RTCAL, then restart right away
        bq.delete();
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        drive_frame(1'b0, 2, bq, 302, 0, 301, -1);
        check("abt_done", ones(got_done, 0, 301), 0);
        check("abt_err", ones(got_err, 0, 301), 0);
        check("abt_busy_in", int'(got_busy[301]), 1);
        total = build_exp(1'b0, bq);
        drive_frame(1'b0, 2, bq, total + 3, 0, -1, -1);
        check("abt_next", int'({got_rd[0], got_busy[0]}), 2);
        check_frame("abt_restart", total, 2);

        // abort beats a same-cycle start in IDLE
        drive_frame(1'b0, 2, bq, 6, 0, 0, -1);
        check("abt_start_busy", ones(got_busy, 0, 5), 0);
        check("abt_start_rd", ones(got_rd, 0, 5), 6);

        // zero-length start is ignored
        drive_frame(1'b0, 0, empty_q, 6, 0, -1, -1);
        check("len0_busy", ones(got_busy, 0, 5), 0);
        check("len0_rd", ones(got_rd, 0, 5), 6);

        // start pulsed mid-command changes nothing
        total = build_exp(1'b0, bq);
        drive_frame(1'b0, 2, bq, total + 3, 0, -1, 700);
        check_frame("midstart", total, 2);

        // async reset in DATA, then a fresh command
        bq.delete();
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        drive_frame(1'b0, 4, bq, 700, 0, -1, -1);
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_outs", int'({rd_data, busy, done,
              cmd_if.bit_ready, err_underrun}), 16);
        repeat (2) @(posedge clk_10m);
        #1;
        rst_n = 1'b1;
        @(posedge clk_10m);
        #1;
        total = build_exp(1'b0, bq);
        drive_frame(1'b0, 4, bq, total + 3, 0, -1, -1);
        check_frame("post_rst", total, 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
